// File: rtl/blk_3398b2_if.sv
// blk_3398b2_if: plaintext/key inputs and ciphertext/done outputs of the PRESENT core.
interface blk_3398b2_if;
  logic [63:0] state;
  logic [79:0] keys;
  logic [63:0] result;
  logic        done;
  modport master (output state, keys, input result, done);
  modport slave (input state, keys, output result, done);
endinterface

// File: rtl/blk_3398b2.sv
// blk_3398b2: free-running iterative PRESENT-80 encryptor, one round per clock, 33-cycle cadence.
module blk_3398b2 (
  input logic         clk,
  input logic         rst_n,
  blk_3398b2_if.slave bus
);
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
  logic [63:0] data_q, data_d, result_q, result_d, mixed, subst, perm, rev;
  logic [79:0] key_q, key_d, rot, key_nx;
  logic [5:0]  rc_q, rc_d;
  logic        done_q, done_d;
  function automatic logic [3:0] sbox(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction
  assign mixed  = data_q ^ key_q[79:16];
  assign rot    = {key_q[18:0], key_q[79:19]};
  assign key_nx = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ rc_q[4:0], rot[14:0]};
  always_comb begin
    subst = '0;
    perm  = '0;
    rev   = '0;
    for (int i = 0; i < 16; i++) subst[4*i +: 4] = sbox(mixed[4*i +: 4]);
    for (int i = 0; i < 63; i++) perm[(16*i) % 63] = subst[i];
    perm[63] = subst[63];
    for (int i = 0; i < 64; i++) rev[i] = mixed[63-i];
  end
  // rc doubles as the phase: 0 = LOAD, 1..31 = ROUND, 32 = FINAL
  always_comb begin
    data_d   = data_q;
    key_d    = key_q;
    rc_d     = rc_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (rc_q == 6'd0) begin
      data_d = bus.state;
      key_d  = bus.keys;
      rc_d   = 6'd1;
    end else if (rc_q == 6'd32) begin
      result_d = rev;
      done_d   = 1'b1;
      rc_d     = 6'd0;
    end else begin
      data_d = perm;
      key_d  = key_nx;
      rc_d   = rc_q + 6'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      key_q    <= '0;
      rc_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      key_q    <= key_d;
      rc_q     <= rc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_blk_3398b2.sv
// tb_blk_3398b2: directed and random PRESENT-80 vectors against a round-key-table reference model.
module tb_blk_3398b2;
  logic clk = 1'b0;
  logic rst_n;
  int passed = 0;
  int total = 0;
  logic [63:0] prev_res;
  logic [63:0] sa, sb_v;
  logic [79:0] ka, kb;
  blk_3398b2_if bus ();
  blk_3398b2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] present(input logic [63:0] pt, input logic [79:0] k);
    logic [3:0]  sb [16];
    logic [63:0] rk [32];
    logic [79:0] kr;
    logic [63:0] s, t;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD, 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    kr = k;
    for (int r = 1; r <= 32; r++) begin
      rk[r-1] = kr[79:16];
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sb[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 0; r < 31; r++) begin
      s = s ^ rk[r];
      for (int j = 0; j < 16; j++) t[4*j +: 4] = sb[s[4*j +: 4]];
      for (int i = 0; i < 64; i++) s[i/4 + (i%4)*16] = t[i];
    end
    return s ^ rk[31];
  endfunction

  function automatic logic [63:0] bitrev(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One 33-edge encryption starting at a LOAD edge; optionally swaps inputs mid-flight.
  task automatic run(input string tag, input logic [63:0] exp_ct, input int chg_at,
                     input logic [63:0] ns, input logic [79:0] nk);
    logic early, moved;
    early = 1'b0;
    moved = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      if (bus.done !== 1'b0) early = 1'b1;
      if (bus.result !== prev_res) moved = 1'b1;
      if (i == chg_at) begin
        bus.state = ns;
        bus.keys  = nk;
      end
    end
    chk({tag, "_done_quiet"}, 64'(early), 64'd0);
    chk({tag, "_hold"}, 64'(moved), 64'd0);
    tick(1);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_ct"}, bitrev(bus.result), exp_ct);
    prev_res = bus.result;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.state = '1;
    bus.keys = '1;
    prev_res = '0;
    tick(2);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    run("ones_ones", 64'h3333DCD3213210D2, 0, '0, '0);
    bus.state = '0;
    bus.keys = '0;
    run("zero_zero", 64'h5579C1387B228445, 0, '0, '0);
    bus.keys = '1;
    run("zero_ones", 64'hE72C46C0F5945049, 0, '0, '0);
    bus.state = '1;
    bus.keys = '0;
    repeat (3) run("ones_zero", 64'hA112FFC72F68417B, 0, '0, '0);
    sa = {$urandom, $urandom};
    ka = {16'($urandom), $urandom, $urandom};
    sb_v = {$urandom, $urandom};
    kb = {16'($urandom), $urandom, $urandom};
    bus.state = sa;
    bus.keys = ka;
    run("chg_old", present(sa, ka), 10, sb_v, kb);
    run("chg_new", present(sb_v, kb), 0, '0, '0);
    for (int v = 0; v < 4; v++) begin
      sa = {$urandom, $urandom};
      ka = {16'($urandom), $urandom, $urandom};
      bus.state = sa;
      bus.keys = ka;
      run("rand", present(sa, ka), 0, '0, '0);
    end
    sa = {$urandom, $urandom};
    ka = {16'($urandom), $urandom, $urandom};
    bus.state = sa;
    bus.keys = ka;
    tick(19);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    prev_res = '0;
    run("after_rst", present(sa, ka), 0, '0, '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
